// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with a 2-entry skid buffer.
// The head (main) entry drives the outputs; the skid entry absorbs the one
// beat that can arrive while downstream stalls, so in_ready is a pure register.
// Bubbles present zero control (and optionally zero data) to the next stage.
module pipe_stage_buf #(
  parameter int CTRL_W    = 12,
  parameter int DATA_W    = 175,
  parameter int ZERO_DATA = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_vld_q, main_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic              in_ready_q;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              accept;
  logic              rel;

  // Next-state for entries and bubble counter; flush wins over accept/release.
  always_comb begin
    accept       = in_valid & in_ready_q;
    rel          = main_vld_q & out_ready;
    main_vld_d   = main_vld_q;
    skid_vld_d   = skid_vld_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    bubble_cnt_d = bubble_cnt_q;

    if (flush) begin
      // Payload registers are left untouched so a held out_data survives.
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (rel) begin
      if (skid_vld_q) begin
        // in_ready is low whenever skid is full, so no accept can coincide.
        main_vld_d  = 1'b1;
        main_ctrl_d = skid_ctrl_q;
        main_data_d = skid_data_q;
        skid_vld_d  = 1'b0;
      end else if (accept) begin
        main_vld_d  = 1'b1;
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_vld_q) begin
        main_vld_d  = 1'b1;
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end else begin
        skid_vld_d  = 1'b1;
        skid_ctrl_d = in_ctrl;
        skid_data_d = in_data;
      end
    end

    if (out_ready && !main_vld_q && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  // Control state: valid bits, registered ready and bubble counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q   <= 1'b0;
      skid_vld_q   <= 1'b0;
      in_ready_q   <= 1'b1;
      bubble_cnt_q <= '0;
    end else begin
      main_vld_q   <= main_vld_d;
      skid_vld_q   <= skid_vld_d;
      in_ready_q   <= !skid_vld_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Payload registers; head data only needs clearing when it is not masked.
  always_ff @(posedge clk) begin
    main_ctrl_q <= main_ctrl_d;
    skid_ctrl_q <= skid_ctrl_d;
    skid_data_q <= skid_data_d;
    if (rst && (ZERO_DATA == 0)) begin
      main_data_q <= '0;
    end else begin
      main_data_q <= main_data_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_vld_q;
  assign out_ctrl   = main_vld_q ? main_ctrl_q : '0;
  assign out_data   = ((ZERO_DATA != 0) && !main_vld_q) ? '0 : main_data_q;
  assign occupancy  = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: two instances (masked data / 16-bit counter and
// held data / 2-bit counter) share one stimulus stream and one FIFO model.
module tb_pipe_stage_buf;

  localparam int CW = 12;
  localparam int DW = 175;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          a_in_ready, a_out_valid;
  logic [CW-1:0] a_out_ctrl;
  logic [DW-1:0] a_out_data;
  logic [1:0]    a_occ;
  logic [15:0]   a_bcnt;

  logic          b_in_ready, b_out_valid;
  logic [CW-1:0] b_out_ctrl;
  logic [DW-1:0] b_out_data;
  logic [1:0]    b_occ;
  logic [1:0]    b_bcnt;

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .ZERO_DATA(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data), .occupancy(a_occ), .bubble_cnt(a_bcnt));

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .ZERO_DATA(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data), .occupancy(b_occ), .bubble_cnt(b_bcnt));

  always #5 clk = ~clk;

  // Reference model: a bounded FIFO of beats, plus bubble counters.
  beat_t         mq[$];
  int            m_occ = 0;
  int            bc16 = 0;
  int            bc2 = 0;
  logic [DW-1:0] last_d = '0;
  logic          acc_last = 1'b0;
  logic          chk_en = 1'b0;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model update at the clock edge: capture accepted beats, apply flush/reset.
  initial begin
    logic acc;
    forever begin
      @(posedge clk);
      acc = in_valid && (m_occ < 2);
      if (rst) begin
        mq.delete();
        bc16     = 0;
        bc2      = 0;
        last_d   = '0;
        acc_last = 1'b0;
      end else begin
        if (out_ready && m_occ == 0) begin
          if (bc16 < 65535) bc16++;
          if (bc2 < 3) bc2++;
        end
        if (flush) mq.delete();
        else if (acc) mq.push_back({in_ctrl, in_data});
        acc_last = acc;
      end
    end
  end

  // Monitor: compare DUT outputs mid-cycle, pop delivered beats.
  initial begin
    int    occ;
    beat_t h;
    forever begin
      @(negedge clk);
      occ   = mq.size();
      m_occ = occ;
      if (chk_en) begin
        chk("a_occupancy", 192'(a_occ), 192'(occ));
        chk("b_occupancy", 192'(b_occ), 192'(occ));
        chk("a_in_ready", 192'(a_in_ready), 192'(occ < 2));
        chk("b_in_ready", 192'(b_in_ready), 192'(occ < 2));
        chk("a_out_valid", 192'(a_out_valid), 192'(occ > 0));
        chk("b_out_valid", 192'(b_out_valid), 192'(occ > 0));
        chk("a_bubble_cnt", 192'(a_bcnt), 192'(bc16));
        chk("b_bubble_cnt", 192'(b_bcnt), 192'(bc2));
        if (occ > 0) begin
          h = mq[0];
          chk("a_out_ctrl", 192'(a_out_ctrl), 192'(h.c));
          chk("a_out_data", 192'(a_out_data), 192'(h.d));
          chk("b_out_ctrl", 192'(b_out_ctrl), 192'(h.c));
          chk("b_out_data", 192'(b_out_data), 192'(h.d));
        end else begin
          chk("a_bubble_ctrl", 192'(a_out_ctrl), 192'(0));
          chk("a_bubble_data", 192'(a_out_data), 192'(0));
          chk("b_bubble_ctrl", 192'(b_out_ctrl), 192'(0));
          chk("b_held_data", 192'(b_out_data), 192'(last_d));
        end
      end
      if (occ > 0) begin
        last_d = mq[0].d;
        if (out_ready) void'(mq.pop_front());
      end
    end
  end

  task automatic step(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic ordy, input logic fl, input logic r);
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
    int n;
    n = 0;
    do begin
      step(1'b1, c, d, ordy, 1'b0, 1'b0);
      n++;
    end while (!acc_last && n < 20);
    n_chk++;
    if (!acc_last) begin
      n_err++;
      $display("FAIL push_timeout: ctrl %0d not accepted after %0d cycles", c, n);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  initial begin
    in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    out_ready = 1'b0; flush = 1'b0; rst = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;

    // Bubbles straight after reset: 5 on the wide counter, 3 on the 2-bit one.
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) push(CW'(i), DW'(8'hA0 + i - 1), 1'b1);
    idle(3);

    // Back-pressure: fill both entries, hold beat 3 upstream, then drain.
    push(CW'(1), DW'(16'hB001), 1'b1);
    push(CW'(2), DW'(16'hB002), 1'b0);
    step(1'b1, CW'(3), DW'(16'hB003), 1'b0, 1'b0, 1'b0);
    step(1'b1, CW'(3), DW'(16'hB003), 1'b0, 1'b0, 1'b0);
    push(CW'(3), DW'(16'hB003), 1'b1);
    idle(4);

    // Flush at full occupancy with a beat offered in the same cycle.
    push(CW'(5), DW'(16'hC005), 1'b0);
    push(CW'(6), DW'(16'hC006), 1'b0);
    step(1'b1, CW'(7), DW'(16'hC007), 1'b0, 1'b1, 1'b0);
    idle(3);

    // Reset together with flush and a beat offered.
    push(CW'(5), DW'(16'hD005), 1'b0);
    push(CW'(6), DW'(16'hD006), 1'b0);
    step(1'b1, CW'(7), DW'(16'hD007), 1'b0, 1'b1, 1'b1);
    idle(3);

    // Held data after drain on the unmasked instance.
    push(CW'(9), DW'(16'h1234), 1'b1);
    idle(4);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, CW'($urandom()), rnd_data(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) == 0);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
